hybrid_branch_predictor: RTL
============================

# hybrid_branch_predictor

Parametrised successor to the fetch-stage predictor. It provides bimodal, gshare or tournament (bimodal + gshare + chooser) prediction, selected at elaboration. Counters train non-speculatively at ALU resolve. The global history register (GHR) is updated speculatively and repaired on mispredict from a checkpoint carried down the pipe. The block sits beside the I-cache in fetch, is fed back from the ALU stage, and exports performance counters.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width
- INDEX_BITS, 8, table index width; each table holds 2**INDEX_BITS 2-bit counters
- GHR_SIZE, 8, history length; must be ≤ INDEX_BITS
- MODE, 2, prediction mode: 0 bimodal, 1 gshare, 2 tournament

Ports:
- i_Clk  in  1  clock
- i_Reset_n  in  1  synchronous, active-low reset
- i_IMEM_address  in  INDEX_BITS  fetch PC index bits
- i_IMEM_inst  in  DATA_WIDTH  fetched instruction
- i_IMEM_valid  in  1  fetch slot valid (low = stall/bubble)
- o_valid  out  1  fetched instruction is a conditional branch
- o_taken  out  1  prediction
- o_ghr  out  GHR_SIZE  GHR value used for this prediction; pipeline carries it to the ALU stage
- o_ready  out  1  table init sweep complete
- i_ALU_isbranch  in  1  ALU-stage instruction is a branch
- i_ALU_outcome  in  1  resolved direction (1 = taken)
- i_ALU_prediction  in  1  prediction made for that branch
- i_ALU_pc  in  INDEX_BITS  branch PC index bits
- i_ALU_ghr  in  GHR_SIZE  checkpointed GHR for that branch
- o_mispredict  out  1  comb: i_ALU_isbranch & (i_ALU_outcome != i_ALU_prediction)
- o_branch_count  out  32  resolved branches
- o_mispredict_count  out  32  mispredicted branches

## Operation
- Branch decode: o_valid = (inst[31:28]==4'b0001) | (inst[31:26]==6'b000001).
- Indices:
  - bimodal index = PC.
  - gshare index = PC ^ zero-extended GHR.
  - Chooser index = PC.
- Prediction (combinational table read):
  - MODE 0: bimodal msb.
  - MODE 1: gshare msb.
  - MODE 2: chooser ≥ 2 ? gshare msb : bimodal msb.
- State machine:
  - INIT: a sweep counter walks 0..2**INDEX_BITS-1, one entry per cycle. It writes 2'b10 to the bimodal and gshare tables and 2'b01 (weakly bimodal) to the chooser. After the last entry the block enters RUN.
  - RUN: normal operation.
  - During INIT: o_ready=0, o_taken=0, GHR held, ALU inputs ignored, perf counters held.
- Speculative GHR (RUN only):
  - If fetch is valid, o_valid=1 and there is no mispredict this cycle: GHR <= {GHR[GHR_SIZE-2:0], o_taken}.
  - On mispredict: GHR <= {i_ALU_ghr[GHR_SIZE-2:0], i_ALU_outcome}. Repair has priority; the fetched instruction is wrong-path.
- Resolve training (RUN, i_ALU_isbranch=1):
  - Indices are recomputed from i_ALU_pc and i_ALU_ghr.
  - Bimodal and gshare counters: saturating +1 if taken, −1 if not, clamped 0..3. Only the tables used by MODE are written.
  - Chooser (MODE 2, pre-update values): +1 (saturating) if gshare msb==outcome and bimodal msb!=outcome; −1 in the opposite case; otherwise unchanged.
- Perf counters:
  - o_branch_count +1 per resolved branch.
  - o_mispredict_count +1 per mispredict.
  - Both saturate at 32'hFFFFFFFF.
- Reset:
  - Effects: state=INIT, sweep=0, GHR=0, perf counters=0, o_ready=0.
  - Reset asserted mid-sweep or mid-run restarts the sweep from 0.

## Timing
- Prediction is combinational: o_taken/o_ghr are valid in the same cycle as i_IMEM_address/i_IMEM_inst.
- Table writes and GHR updates take effect at the next posedge. A fetch read and a resolve write to the same entry in the same cycle returns the old value.
- The sweep lasts 2**INDEX_BITS cycles after reset deasserts. o_ready rises on the cycle after the last write.
- Each table has one write port. The resolve write and the sweep write are mutually exclusive by state.
- Stall (i_IMEM_valid=0) freezes the GHR unless a mispredict repair occurs in that cycle.

## Structure
- Shared package bp_pkg holds:
  - MODE encodings
  - the 2-bit counter typedef
  - counter init constants (2'b10, 2'b01)
  - branch opcode constants
  - the saturating inc/dec function
- Sub-module bp_counter_table: a 2**INDEX_BITS × 2-bit array with:
  - async fetch read port
  - async resolve read port
  - one sync write port
  - init-sweep write mux
- bp_counter_table is instantiated three times: bimodal, gshare, chooser. The chooser instance is omitted when MODE≠2.
- The top level holds the FSM, GHR, decode and perf counters.

## Test plan
- Reset, then count cycles → o_ready=0 for exactly 256 cycles (INDEX_BITS=8), then 1; every entry reads 2'b10 (chooser 2'b01).
- MODE 0: resolve PC 0x12 not-taken 3× → counter 10→01→00→00 (saturates); fetch PC 0x12 gives o_taken=0.
- MODE 1: GHR=0, fetch three predicted-taken branches → o_ghr 0x00, 0x01, 0x03. Then mispredict with i_ALU_ghr=0x01, outcome 0 → GHR=0x02 next cycle, and a same-cycle fetch does not shift.
- MODE 2: bimodal correct, gshare wrong at PC 0x05 → chooser 01→00; reverse case twice → 00→01→10, and predictions switch to gshare.
- Assert reset at sweep index 100 → sweep restarts from 0, GHR=0, counters=0; o_ready is delayed a full 256 cycles.
- Force 2**32 mispredicts (preload via hierarchical force) → o_mispredict_count holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/hybrid_branch_predictor_pkg.sv
// hybrid_branch_predictor_pkg: shared modes, counter type, init constants, opcodes and saturating update
package hybrid_branch_predictor_pkg;
    localparam int MODE_BIMODAL    = 0;
    localparam int MODE_GSHARE     = 1;
    localparam int MODE_TOURNAMENT = 2;
    typedef logic [1:0] ctr_t;
    typedef enum logic {INIT, RUN} state_t;
    localparam ctr_t CTR_INIT     = 2'b10;
    localparam ctr_t CHOOSER_INIT = 2'b01;
    localparam logic [3:0] OP_BR4 = 4'b0001;
    localparam logic [5:0] OP_BR6 = 6'b000001;
    function automatic ctr_t ctr_update(ctr_t c, logic up);
        return up ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/hybrid_branch_predictor_if.sv
// hybrid_branch_predictor_if: fetch, resolve and perf-counter signals of the predictor.
//   fetch   : i_IMEM_address/inst/valid in, o_valid/o_taken/o_ghr/o_ready out
//   resolve : i_ALU_isbranch/outcome/prediction/pc/ghr in, o_mispredict out
//   perf    : o_branch_count, o_mispredict_count out
interface hybrid_branch_predictor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int GHR_SIZE   = 8
);
    logic [INDEX_BITS-1:0] i_IMEM_address;
    logic [DATA_WIDTH-1:0] i_IMEM_inst;
    logic                  i_IMEM_valid;
    logic                  o_valid;
    logic                  o_taken;
    logic [GHR_SIZE-1:0]   o_ghr;
    logic                  o_ready;
    logic                  i_ALU_isbranch;
    logic                  i_ALU_outcome;
    logic                  i_ALU_prediction;
    logic [INDEX_BITS-1:0] i_ALU_pc;
    logic [GHR_SIZE-1:0]   i_ALU_ghr;
    logic                  o_mispredict;
    logic [31:0]           o_branch_count;
    logic [31:0]           o_mispredict_count;
    modport master (
        output i_IMEM_address, i_IMEM_inst, i_IMEM_valid,
        output i_ALU_isbranch, i_ALU_outcome, i_ALU_prediction, i_ALU_pc, i_ALU_ghr,
        input  o_valid, o_taken, o_ghr, o_ready, o_mispredict, o_branch_count, o_mispredict_count
    );
    modport slave (
        input  i_IMEM_address, i_IMEM_inst, i_IMEM_valid,
        input  i_ALU_isbranch, i_ALU_outcome, i_ALU_prediction, i_ALU_pc, i_ALU_ghr,
        output o_valid, o_taken, o_ghr, o_ready, o_mispredict, o_branch_count, o_mispredict_count
    );
endinterface

// File: rtl/hybrid_branch_predictor_table.sv
// hybrid_branch_predictor_table: 2**INDEX_BITS x 2-bit counter array.
//   clk_i; init_i/sweep_idx_i drive the init sweep write; fetch_idx_i/fetch_o and
//   res_idx_i/res_o are async reads; wr_en_i/wr_data_i write res_idx_i outside init.
module hybrid_branch_predictor_table import hybrid_branch_predictor_pkg::*; #(
    parameter int   INDEX_BITS = 8,
    parameter ctr_t INIT_VAL   = CTR_INIT
) (
    input  logic                  clk_i,
    input  logic                  init_i,
    input  logic [INDEX_BITS-1:0] sweep_idx_i,
    input  logic [INDEX_BITS-1:0] fetch_idx_i,
    input  logic [INDEX_BITS-1:0] res_idx_i,
    output ctr_t                  fetch_o,
    output ctr_t                  res_o,
    input  logic                  wr_en_i,
    input  ctr_t                  wr_data_i
);
    ctr_t mem_q [2**INDEX_BITS];
    assign fetch_o = mem_q[fetch_idx_i];
    assign res_o   = mem_q[res_idx_i];
    // single write port shared by the init sweep and resolve training
    always_ff @(posedge clk_i)
        if (init_i || wr_en_i) mem_q[init_i ? sweep_idx_i : res_idx_i] <= init_i ? INIT_VAL : wr_data_i;
endmodule

// File: rtl/hybrid_branch_predictor.sv
// hybrid_branch_predictor: bimodal/gshare/tournament predictor with speculative GHR and perf counters.
//   i_Clk, i_Reset_n (sync, active-low); bp carries fetch, resolve and perf-counter signals.
module hybrid_branch_predictor import hybrid_branch_predictor_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int GHR_SIZE   = 8,
    parameter int MODE       = 2
) (
    input logic i_Clk,
    input logic i_Reset_n,
    hybrid_branch_predictor_if.slave bp
);
    state_t                state_q;
    logic [INDEX_BITS-1:0] sweep_q;
    logic [GHR_SIZE-1:0]   ghr_q, ghr_d;
    logic [31:0]           br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
    logic                  run, train, mp, pred;
    ctr_t                  bim_f, bim_r, gsh_f, gsh_r, ch_f;

    assign run   = state_q == RUN;
    // opcode field sits in the top bits of the instruction word
    assign bp.o_valid = bp.i_IMEM_inst[DATA_WIDTH-1 -: 4] == OP_BR4 || bp.i_IMEM_inst[DATA_WIDTH-1 -: 6] == OP_BR6;
    assign pred  = (MODE == MODE_BIMODAL) ? bim_f[1] : (MODE == MODE_GSHARE) ? gsh_f[1] : (ch_f[1] ? gsh_f[1] : bim_f[1]);
    assign bp.o_taken = run && pred;
    assign bp.o_ghr   = ghr_q;
    assign bp.o_ready = run;
    assign bp.o_mispredict = bp.i_ALU_isbranch && (bp.i_ALU_outcome != bp.i_ALU_prediction);
    assign bp.o_branch_count     = br_cnt_q;
    assign bp.o_mispredict_count = mp_cnt_q;
    assign train = run && bp.i_ALU_isbranch;
    assign mp    = run && bp.o_mispredict;
    // repair wins over the speculative shift: the fetched instruction is wrong-path
    assign ghr_d = mp ? GHR_SIZE'({bp.i_ALU_ghr, bp.i_ALU_outcome})
                 : (run && bp.i_IMEM_valid && bp.o_valid) ? GHR_SIZE'({ghr_q, pred}) : ghr_q;
    assign br_cnt_d = (train && !(&br_cnt_q)) ? br_cnt_q + 32'd1 : br_cnt_q;
    assign mp_cnt_d = (mp && !(&mp_cnt_q)) ? mp_cnt_q + 32'd1 : mp_cnt_q;

    always_ff @(posedge i_Clk)
        if (!i_Reset_n) begin
            state_q  <= INIT;
            sweep_q  <= '0;
            ghr_q    <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (!run) begin
                sweep_q <= sweep_q + 1'b1;
                if (&sweep_q) state_q <= RUN;
            end
            ghr_q    <= ghr_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end

    hybrid_branch_predictor_table #(.INDEX_BITS(INDEX_BITS), .INIT_VAL(CTR_INIT)) u_bim (
        .clk_i(i_Clk), .init_i(!run), .sweep_idx_i(sweep_q),
        .fetch_idx_i(bp.i_IMEM_address), .res_idx_i(bp.i_ALU_pc),
        .fetch_o(bim_f), .res_o(bim_r),
        .wr_en_i(train && MODE != MODE_GSHARE), .wr_data_i(ctr_update(bim_r, bp.i_ALU_outcome))
    );

    hybrid_branch_predictor_table #(.INDEX_BITS(INDEX_BITS), .INIT_VAL(CTR_INIT)) u_gsh (
        .clk_i(i_Clk), .init_i(!run), .sweep_idx_i(sweep_q),
        .fetch_idx_i(bp.i_IMEM_address ^ INDEX_BITS'(ghr_q)),
        .res_idx_i(bp.i_ALU_pc ^ INDEX_BITS'(bp.i_ALU_ghr)),
        .fetch_o(gsh_f), .res_o(gsh_r),
        .wr_en_i(train && MODE != MODE_BIMODAL), .wr_data_i(ctr_update(gsh_r, bp.i_ALU_outcome))
    );

    if (MODE == MODE_TOURNAMENT) begin : g_ch
        ctr_t ch_r, ch_w;
        logic g_ok, b_ok;
        assign g_ok = gsh_r[1] == bp.i_ALU_outcome;
        assign b_ok = bim_r[1] == bp.i_ALU_outcome;
        // move toward whichever component alone was right; ties leave the chooser alone
        assign ch_w = (g_ok && !b_ok) ? ctr_update(ch_r, 1'b1) : (b_ok && !g_ok) ? ctr_update(ch_r, 1'b0) : ch_r;
        hybrid_branch_predictor_table #(.INDEX_BITS(INDEX_BITS), .INIT_VAL(CHOOSER_INIT)) u_ch (
            .clk_i(i_Clk), .init_i(!run), .sweep_idx_i(sweep_q),
            .fetch_idx_i(bp.i_IMEM_address), .res_idx_i(bp.i_ALU_pc),
            .fetch_o(ch_f), .res_o(ch_r),
            .wr_en_i(train), .wr_data_i(ch_w)
        );
    end else begin : g_no_ch
        assign ch_f = CHOOSER_INIT;
    end
endmodule
